// File: rtl/fft_bfly_pkg.sv
// Shared widths and arithmetic helpers for the radix-2 butterfly datapath.
// Latency: none (types, constants and combinational functions only).
// Backpressure: not applicable; helpers take widths as arguments so any DATA_W/TW_W works.
package fft_bfly_pkg;

  // Default operand widths and the intermediate widths they imply
  localparam int DATA_W_DEF = 8;
  localparam int TW_W_DEF   = 8;
  localparam int PROD_W     = DATA_W_DEF + TW_W_DEF;      // one real product
  localparam int WB_W       = PROD_W + 1;                 // sum/difference of two products
  localparam int SUM_W      = DATA_W_DEF + 3;             // A +/- rounded W*B

  // Wide carrier for the width-agnostic helpers below
  typedef logic signed [63:0] wide_t;

  function automatic int prod_w(input int dw, input int tw);
    return dw + tw;
  endfunction

  function automatic int wb_w(input int dw, input int tw);
    return dw + tw + 1;
  endfunction

  function automatic int rnd_w(input int dw);
    return dw + 2;
  endfunction

  function automatic int sum_w(input int dw);
    return dw + 3;
  endfunction

  // Round half-up, then arithmetic shift right by sh (sh >= 1)
  function automatic wide_t rnd_shr(input wide_t x, input int sh);
    return (x + (64'sd1 <<< (sh - 1))) >>> sh;
  endfunction

  // Clamp x into the signed w-bit range; ovf reports whether clamping happened
  function automatic wide_t sat(input wide_t x, input int w, output logic ovf);
    wide_t hi;
    wide_t lo;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    ovf = 1'b0;
    sat = x;
    if (x > hi) begin
      sat = hi;
      ovf = 1'b1;
    end else if (x < lo) begin
      sat = lo;
      ovf = 1'b1;
    end
  endfunction

endpackage

// File: rtl/fft_cmul_round.sv
// Complex multiply W*B with half-up rounding back to DATA_W+2 bits; A and scale ride along.
// Latency: 2 cycles (S1 products, S2 combine + round), both stages load only on adv.
// Backpressure: holds all state while adv is low; clear zeroes both valid bits.
module fft_cmul_round
  import fft_bfly_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TW_W   = TW_W_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic                            adv,
  input  logic                            in_valid,
  input  logic                            in_scale,
  input  logic signed [DATA_W-1:0]        a_re,
  input  logic signed [DATA_W-1:0]        a_im,
  input  logic signed [DATA_W-1:0]        b_re,
  input  logic signed [DATA_W-1:0]        b_im,
  input  logic signed [TW_W-1:0]          w_re,
  input  logic signed [TW_W-1:0]          w_im,
  output logic                            s2_valid,
  output logic                            s2_scale,
  output logic signed [DATA_W-1:0]        s2_a_re,
  output logic signed [DATA_W-1:0]        s2_a_im,
  output logic signed [rnd_w(DATA_W)-1:0] s2_wb_re,
  output logic signed [rnd_w(DATA_W)-1:0] s2_wb_im
);

  localparam int PW = prod_w(DATA_W, TW_W);
  localparam int WW = wb_w(DATA_W, TW_W);
  localparam int RW = rnd_w(DATA_W);

  logic                     s1_valid;
  logic                     s1_scale;
  logic signed [DATA_W-1:0] s1_a_re;
  logic signed [DATA_W-1:0] s1_a_im;
  logic signed [PW-1:0]     p_rr;
  logic signed [PW-1:0]     p_ii;
  logic signed [PW-1:0]     p_ri;
  logic signed [PW-1:0]     p_ir;
  logic signed [WW-1:0]     wb_re;
  logic signed [WW-1:0]     wb_im;
  logic signed [RW-1:0]     wb_re_rnd;
  logic signed [RW-1:0]     wb_im_rnd;

  // S1: register the four partial products together with A and the scale flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_scale <= 1'b0;
      s1_a_re  <= '0;
      s1_a_im  <= '0;
      p_rr     <= '0;
      p_ii     <= '0;
      p_ri     <= '0;
      p_ir     <= '0;
    end else begin
      if (clear)    s1_valid <= 1'b0;
      else if (adv) s1_valid <= in_valid;
      if (adv) begin
        s1_scale <= in_scale;
        s1_a_re  <= a_re;
        s1_a_im  <= a_im;
        p_rr     <= PW'(b_re) * PW'(w_re);
        p_ii     <= PW'(b_im) * PW'(w_im);
        p_ri     <= PW'(b_re) * PW'(w_im);
        p_ir     <= PW'(b_im) * PW'(w_re);
      end
    end
  end

  // Combine products; twiddles are Q1.(TW_W-1) so drop TW_W-1 fraction bits with rounding
  assign wb_re     = WW'(p_rr) - WW'(p_ii);
  assign wb_im     = WW'(p_ri) + WW'(p_ir);
  assign wb_re_rnd = RW'(rnd_shr(64'(wb_re), TW_W - 1));
  assign wb_im_rnd = RW'(rnd_shr(64'(wb_im), TW_W - 1));

  // S2: register the rounded W*B terms and delay A alongside
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_scale <= 1'b0;
      s2_a_re  <= '0;
      s2_a_im  <= '0;
      s2_wb_re <= '0;
      s2_wb_im <= '0;
    end else begin
      if (clear)    s2_valid <= 1'b0;
      else if (adv) s2_valid <= s1_valid;
      if (adv) begin
        s2_scale <= s1_scale;
        s2_a_re  <= s1_a_re;
        s2_a_im  <= s1_a_im;
        s2_wb_re <= wb_re_rnd;
        s2_wb_im <= wb_im_rnd;
      end
    end
  end

endmodule

// File: rtl/fft_bfly_pipe.sv
// Radix-2 DIT butterfly Y = A + W*B, Z = A - W*B with optional per-beat /2; FFT_BFLY_SAT_EN selects clamping + out_ovf instead of wrap.
// Latency: 3 register stages (S1, S2 in fft_cmul_round, S3 here); one beat per cycle when unstalled.
// Backpressure: single global stall, adv = !out_valid || out_ready; bubbles are not collapsed; clear flushes all stages.
module fft_bfly_pipe
  import fft_bfly_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TW_W   = TW_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_scale,
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  input  logic signed [TW_W-1:0]   w_re,
  input  logic signed [TW_W-1:0]   w_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] y_re,
  output logic signed [DATA_W-1:0] y_im,
  output logic signed [DATA_W-1:0] z_re,
  output logic signed [DATA_W-1:0] z_im,
  output logic                     out_ovf
);

  localparam int RW = rnd_w(DATA_W);
  localparam int SW = sum_w(DATA_W);

  logic                     adv;
  logic                     s2_valid;
  logic                     s2_scale;
  logic signed [DATA_W-1:0] s2_a_re;
  logic signed [DATA_W-1:0] s2_a_im;
  logic signed [RW-1:0]     s2_wb_re;
  logic signed [RW-1:0]     s2_wb_im;
  logic signed [SW-1:0]     sum [4];
  wide_t                    v   [4];
  logic signed [DATA_W-1:0] res [4];
`ifdef FFT_BFLY_SAT_EN
  logic [3:0]               clip;
`endif

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !clear;

  fft_cmul_round #(
    .DATA_W (DATA_W),
    .TW_W   (TW_W)
  ) u_cmul (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .adv      (adv),
    .in_valid (in_valid),
    .in_scale (in_scale),
    .a_re     (a_re),
    .a_im     (a_im),
    .b_re     (b_re),
    .b_im     (b_im),
    .w_re     (w_re),
    .w_im     (w_im),
    .s2_valid (s2_valid),
    .s2_scale (s2_scale),
    .s2_a_re  (s2_a_re),
    .s2_a_im  (s2_a_im),
    .s2_wb_re (s2_wb_re),
    .s2_wb_im (s2_wb_im)
  );

  // S3 datapath: A +/- W*B at full width, optional rounded halving, then clamp or wrap to DATA_W
  always_comb begin
`ifdef FFT_BFLY_SAT_EN
    clip = '0;
`endif
    sum[0] = SW'(s2_a_re) + SW'(s2_wb_re);
    sum[1] = SW'(s2_a_im) + SW'(s2_wb_im);
    sum[2] = SW'(s2_a_re) - SW'(s2_wb_re);
    sum[3] = SW'(s2_a_im) - SW'(s2_wb_im);
    for (int i = 0; i < 4; i++) begin
      v[i] = s2_scale ? rnd_shr(64'(sum[i]), 1) : 64'(sum[i]);
`ifdef FFT_BFLY_SAT_EN
      v[i] = sat(v[i], DATA_W, clip[i]);
`endif
      res[i] = DATA_W'(v[i]);
    end
  end

  // S3 register: drives the outputs and holds them while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y_re      <= '0;
      y_im      <= '0;
      z_re      <= '0;
      z_im      <= '0;
    end else begin
      if (clear)    out_valid <= 1'b0;
      else if (adv) out_valid <= s2_valid;
      if (adv) begin
        y_re <= res[0];
        y_im <= res[1];
        z_re <= res[2];
        z_im <= res[3];
      end
    end
  end

`ifdef FFT_BFLY_SAT_EN
  // Overflow flag travels with the beat it belongs to
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      out_ovf <= 1'b0;
    else if (adv) out_ovf <= |clip;
  end
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fft_bfly_pipe.sv
// Self-checking bench for fft_bfly_pipe: directed butterfly vectors, stall, clear, async reset, random soak.
// Reference: integer butterfly arithmetic with floor division and a queue of expected beats.
// Inputs change #1 after the rising edge; outputs and handshakes are sampled on the falling edge.
module tb_fft_bfly_pipe;

  localparam int DW  = 8;
  localparam int TWW = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  clear;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_scale;
  logic signed [DW-1:0]  a_re, a_im, b_re, b_im;
  logic signed [TWW-1:0] w_re, w_im;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [DW-1:0]  y_re, y_im, z_re, z_im;
  logic                  out_ovf;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_out    = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  fft_bfly_pipe #(.DATA_W(DW), .TW_W(TWW)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_scale  (in_scale),
    .a_re      (a_re),
    .a_im      (a_im),
    .b_re      (b_re),
    .b_im      (b_im),
    .w_re      (w_re),
    .w_im      (w_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_re      (y_re),
    .y_im      (y_im),
    .z_re      (z_re),
    .z_im      (z_im),
    .out_ovf   (out_ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Floor division for positive divisors
  function automatic int fdiv(input int n, input int d);
    int q;
    q = n / d;
    if ((n % d) != 0 && n < 0) q--;
    return q;
  endfunction

  // Fit an exact result into DW bits: clamp or two's-complement wrap
  function automatic int reduce(input int x, output bit o);
    int lim;
    lim = 1 << (DW - 1);
    o   = 1'b0;
`ifdef FFT_BFLY_SAT_EN
    if (x > lim - 1) begin o = 1'b1; return lim - 1; end
    if (x < -lim)    begin o = 1'b1; return -lim;    end
    return x;
`else
    return ((x % (2 * lim)) + 3 * lim) % (2 * lim) - lim;
`endif
  endfunction

  function automatic logic [32:0] pk(input int yr, input int yi, input int zr, input int zi, input bit o);
    return {DW'(yr), DW'(yi), DW'(zr), DW'(zi), o};
  endfunction

  // Butterfly on plain integers: W*B rounded half-up to integer, then A +/- W*B, optional halving
  function automatic logic [32:0] model(input int ar, input int ai, input int br, input int bi,
                                        input int wr, input int wi, input bit sc);
    int one, half, wbr, wbi;
    int s[4];
    bit o[4];
    one  = 1 << (TWW - 1);
    half = 1 << (TWW - 2);
    wbr  = fdiv(br * wr - bi * wi + half, one);
    wbi  = fdiv(br * wi + bi * wr + half, one);
    s[0] = ar + wbr;
    s[1] = ai + wbi;
    s[2] = ar - wbr;
    s[3] = ai - wbi;
    for (int i = 0; i < 4; i++) begin
      if (sc) s[i] = fdiv(s[i] + 1, 2);
      s[i] = reduce(s[i], o[i]);
    end
    return pk(s[0], s[1], s[2], s[3], o[0] | o[1] | o[2] | o[3]);
  endfunction

  task automatic rand_beat();
    a_re     = DW'($urandom);
    a_im     = DW'($urandom);
    b_re     = DW'($urandom);
    b_im     = DW'($urandom);
    w_re     = TWW'($urandom);
    w_im     = TWW'($urandom);
    in_scale = 1'($urandom);
  endtask

  // One clock: scoreboard at the falling edge, then advance to just after the rising edge
  task automatic tick();
    logic [32:0] e;
    @(negedge clk);
    if (!rst) begin
      if (clear) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          n_out++;
          check("beat_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("beat_data", 64'({y_re, y_im, z_re, z_im, out_ovf}), 64'(e));
          end
        end
        if (in_valid && in_ready)
          exp_q.push_back(model(int'(a_re), int'(a_im), int'(b_re), int'(b_im),
                                int'(w_re), int'(w_im), in_scale));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Single beat into an idle pipe: check 3-edge latency and the result against a given value
  task automatic run_one(input int ar, input int ai, input int br, input int bi,
                         input int wr, input int wi, input bit sc,
                         input logic [32:0] exp, input string tag);
    int n;
    a_re = DW'(ar); a_im = DW'(ai); b_re = DW'(br); b_im = DW'(bi);
    w_re = TWW'(wr); w_im = TWW'(wi); in_scale = sc;
    in_valid = 1'b1; clear = 1'b0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 8) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(3));
    check({tag, "_dat"}, 64'({y_re, y_im, z_re, z_im, out_ovf}), 64'(exp));
    tick();
  endtask

  initial begin
    int acc, drop_at, out0;
    bit acc_now;

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_scale = 1'b0; out_ready = 1'b1;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld", 64'(out_valid), 64'(0));
    check("rst_dat", 64'({y_re, y_im, z_re, z_im, out_ovf}), 64'(0));
    rst = 1'b0;
    #1;
    check("rst_rdy", 64'(in_ready), 64'(1));

    // Directed butterfly vectors
    run_one(10, 20, 3, -4, -128, 0, 1'b0, pk(7, 24, 13, 16, 1'b0), "w_m1");
    run_one(10, 20, 3, -4, 0, -128, 1'b0, pk(6, 17, 14, 23, 1'b0), "w_mj");
`ifdef FFT_BFLY_SAT_EN
    run_one(127, 0, 127, 0, -128, 0, 1'b0, pk(0, 0, 127, 0, 1'b1), "ovf_s0");
`else
    run_one(127, 0, 127, 0, -128, 0, 1'b0, pk(0, 0, -2, 0, 1'b0), "ovf_s0");
`endif
    run_one(127, 0, 127, 0, -128, 0, 1'b1, pk(0, 0, 127, 0, 1'b0), "ovf_s1");

    // Six back-to-back beats, consumer stalled in cycles 4..8
    acc = 0; drop_at = -1; out0 = n_out;
    rand_beat();
    for (int c = 1; c <= 30; c++) begin
      out_ready = !(c >= 4 && c <= 8);
      in_valid  = (acc < 6);
      #1;
      acc_now = in_valid && in_ready;
      if (!in_ready && drop_at < 0) drop_at = acc;
      tick();
      if (acc_now) begin
        acc++;
        rand_beat();
      end
    end
    check("bp_held", 64'(drop_at), 64'(3));
    check("bp_count", 64'(n_out - out0), 64'(6));
    check("bp_empty", 64'(exp_q.size()), 64'(0));

    // Clear with three beats in flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_beat();
      in_valid = 1'b1;
      tick();
    end
    check("clr_full", 64'(out_valid), 64'(1));
    rand_beat();
    clear = 1'b1;
    #1;
    check("clr_rdy", 64'(in_ready), 64'(0));
    tick();
    clear = 1'b0; in_valid = 1'b0;
    check("clr_vld", 64'(out_valid), 64'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("clr_empty", 64'(out_valid), 64'(0));
    end
    run_one(-50, 33, 100, -7, 90, -60, 1'b1,
            model(-50, 33, 100, -7, 90, -60, 1'b1), "clr_next");

    // Random soak with random stalls and occasional clears
    for (int c = 0; c < 400; c++) begin
      rand_beat();
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      clear     = ($urandom % 40) == 0;
      tick();
    end
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) tick();
    check("soak_drain", 64'(exp_q.size()), 64'(0));

    // Asynchronous reset while a beat is presented
    out_ready = 1'b0; in_valid = 1'b1;
    rand_beat();
    repeat (4) tick();
    check("mid_vld", 64'(out_valid), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_vld", 64'(out_valid), 64'(0));
    check("mid_rst_dat", 64'({y_re, y_im, z_re, z_im, out_ovf}), 64'(0));
    exp_q.delete();
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rdy", 64'(in_ready), 64'(1));
    tick();
    check("mid_idle", 64'(out_valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
